// File: rtl/ks_pkg.sv
// Shared constants and FSM encoding for the nibble-serial Kogge-Stone adder.
package ks_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ks_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/kogge_stone_4bit.sv
// 4-bit Kogge-Stone parallel-prefix adder, purely combinational.
module kogge_stone_4bit (
  input  logic [4:1] A,
  input  logic [4:1] B,
  input  logic       cin,
  output logic       cout,
  output logic [4:1] sum
);

  logic [4:0] g0;
  logic [4:1] p0;
  logic [4:0] g1;
  logic [4:2] p1;
  logic [4:0] g2;
  logic       p2_4;

  // cin rides in as generate at position 0
  always_comb begin
    g0 = {A & B, cin};
    p0 = A ^ B;

    g1[0] = g0[0];
    for (int i = 1; i <= 4; i++)
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
    for (int i = 2; i <= 4; i++)
      p1[i] = p0[i] & p0[i-1];

    g2[1:0] = g1[1:0];
    for (int i = 2; i <= 4; i++)
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
    p2_4 = p1[4] & p1[2];

    cout = g2[4] | (p2_4 & g2[0]);
    for (int i = 1; i <= 4; i++)
      sum[i] = p0[i] ^ g2[i-1];
  end

endmodule

// File: rtl/ks_serial_add_ctrl.sv
// Runs one 4-bit Kogge-Stone adder digit-serially, LSB first,
// to add two N_DIGITS*4-bit operands with a registered ripple carry.
module ks_serial_add_ctrl
  import ks_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4*N_DIGITS-1:0]     a,
  input  logic [4*N_DIGITS-1:0]     b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [4*N_DIGITS-1:0]     sum,
  output logic                      cout,
  output logic                      ovf
);

  localparam int W     = DIGIT_W * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? ks_clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT_W-1:0] ks_a;
  logic [DIGIT_W-1:0] ks_b;
  logic [DIGIT_W-1:0] ks_sum;
  logic               ks_cout;

  assign ks_a = a_q[DIGIT_W*int'(idx_q) +: DIGIT_W];
  assign ks_b = b_q[DIGIT_W*int'(idx_q) +: DIGIT_W];

  kogge_stone_4bit u_ks (
    .A    (ks_a),
    .B    (ks_b),
    .cin  (carry_q),
    .cout (ks_cout),
    .sum  (ks_sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        sum_d[DIGIT_W*int'(idx_q) +: DIGIT_W] = ks_sum;
        carry_d = ks_cout;
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = ks_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                    (ks_sum[DIGIT_W-1] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
